// File: rtl/spi_slave_responder_pkg.sv
// Shared constants and state encoding for the SPI mode-0 slave responder.
package spi_pkg;

  localparam int SPI_FRAME_BITS  = 40;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SHIFT     = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_slave_responder_if.sv
// SPI pad-side bundle: master drives cs_n/sck/mosi, slave drives miso/miso_oe.
interface spi_slave_responder_if;

  logic cs_n;
  logic sck;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output cs_n, output sck, output mosi, input miso, input miso_oe);
  modport slave  (input cs_n, input sck, input mosi, output miso, output miso_oe);

endinterface

// File: rtl/spi_slave_responder_sync_edge.sv
// Multi-FF synchroniser for one asynchronous input, with a registered copy
// used for edge detection; level, rise and fall are mutually time-aligned.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SPI_SYNC_STAGES-1:0] sync_r;
  logic                       level_r;
  logic                       rise_r;
  logic                       fall_r;
  logic                       stage_s;

  assign stage_s = sync_r[SPI_SYNC_STAGES-1];

  // Synchroniser chain plus the compare copy; edges register alongside level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r  <= {SPI_SYNC_STAGES{RESET_VAL}};
      level_r <= RESET_VAL;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SPI_SYNC_STAGES-2:0], din};
      level_r <= stage_s;
      rise_r  <= stage_s & ~level_r;
      fall_r  <= ~stage_s & level_r;
    end
  end

  assign level = level_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave responder, oversampled on clk. Optional frame error
// reporting is built when SPI_SLAVE_FRAME_ERR_EN is defined.
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int SIZE = SPI_FRAME_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SIZE-1:0]      tx_bytes,
  output logic [SIZE-1:0]      rx_bytes,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 frame_err,
  spi_slave_responder_if.slave spi
);

  localparam int              CNT_W      = $clog2(SIZE + 2);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(SIZE);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SIZE + 1);
  localparam logic [1:0]      SETTLE_CNT = 2'(SPI_SYNC_STAGES + 1);

  spi_state_e       state_r;
  spi_state_e       state_nxt;
  logic [1:0]       settle_r;
  logic             settle_done_s;
  logic [SIZE-2:0]  tx_sr_r;
  logic [SIZE-1:0]  rx_sr_r;
  logic [SIZE-1:0]  rx_sr_nxt;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [CNT_W-1:0] bit_cnt_nxt;
  logic [SIZE-1:0]  rx_bytes_r;
  logic             rx_valid_r;
  logic             busy_r;
  logic             miso_r;
  logic             load_s;
  logic             close_s;
  logic             full_s;

  logic cs_level_s, cs_rise_s, cs_fall_s;
  logic sck_level_unused_s, sck_rise_s, sck_fall_s;
  logic mosi_level_s, mosi_rise_unused_s, mosi_fall_unused_s;

  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .din(spi.cs_n),
    .level(cs_level_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .reset(reset), .din(spi.sck),
    .level(sck_level_unused_s), .rise(sck_rise_s), .fall(sck_fall_s)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .reset(reset), .din(spi.mosi),
    .level(mosi_level_s), .rise(mosi_rise_unused_s), .fall(mosi_fall_unused_s)
  );

  // Flush counter so a cs_n already low at reset release is seen before leaving WAIT_IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_r <= 2'd0;
    end else if ((state_r == ST_WAIT_IDLE) && (settle_r != SETTLE_CNT)) begin
      settle_r <= settle_r + 2'd1;
    end else begin
      settle_r <= settle_r;
    end
  end

  assign settle_done_s = (settle_r == SETTLE_CNT);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_WAIT_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state and frame load/close strobes.
  always_comb begin
    state_nxt = state_r;
    load_s    = 1'b0;
    close_s   = 1'b0;
    case (state_r)
      ST_WAIT_IDLE: begin
        if (settle_done_s && cs_level_s) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT_IDLE;
        end
      end
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_nxt = ST_SHIFT;
          load_s    = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cs_rise_s) begin
          state_nxt = ST_IDLE;
          close_s   = 1'b1;
        end else begin
          state_nxt = ST_SHIFT;
        end
      end
      default: begin
        state_nxt = ST_WAIT_IDLE;
      end
    endcase
  end

  // Receive shift and saturating bit count; computed ahead so a same-cycle cs_n rise sees the sck edge.
  always_comb begin
    rx_sr_nxt   = rx_sr_r;
    bit_cnt_nxt = bit_cnt_r;
    if ((state_r == ST_SHIFT) && sck_rise_s) begin
      rx_sr_nxt = {rx_sr_r[SIZE-2:0], mosi_level_s};
      if (bit_cnt_r < CNT_MAX) begin
        bit_cnt_nxt = bit_cnt_r + CNT_W'(1);
      end else begin
        bit_cnt_nxt = bit_cnt_r;
      end
    end else begin
      rx_sr_nxt   = rx_sr_r;
      bit_cnt_nxt = bit_cnt_r;
    end
  end

  assign full_s = (bit_cnt_nxt == CNT_FULL);

  // Frame datapath: load at cs_n fall, shift on sck edges, publish at cs_n rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_sr_r    <= '0;
      rx_sr_r    <= '0;
      bit_cnt_r  <= '0;
      rx_bytes_r <= '0;
      rx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      miso_r     <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      if (load_s) begin
        tx_sr_r   <= tx_bytes[SIZE-2:0];
        bit_cnt_r <= '0;
        miso_r    <= tx_bytes[SIZE-1];
        busy_r    <= 1'b1;
      end else if (close_s) begin
        rx_sr_r   <= rx_sr_nxt;
        bit_cnt_r <= bit_cnt_nxt;
        if (full_s) begin
          rx_bytes_r <= rx_sr_nxt;
          rx_valid_r <= 1'b1;
        end
        busy_r <= 1'b0;
        miso_r <= 1'b0;
      end else if (state_r == ST_SHIFT) begin
        rx_sr_r   <= rx_sr_nxt;
        bit_cnt_r <= bit_cnt_nxt;
        if (sck_fall_s) begin
          tx_sr_r <= {tx_sr_r[SIZE-3:0], 1'b0};
          miso_r  <= (bit_cnt_r >= CNT_FULL) ? 1'b0 : tx_sr_r[SIZE-2];
        end
      end
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err_r;
  logic frame_err_s;

  assign frame_err_s = (close_s && !full_s) ||
                       ((state_r == ST_IDLE) && sck_rise_s && !cs_level_s);

  // One-cycle pulse on a wrong-length frame or sck activity before the frame is open.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= frame_err_s;
    end
  end

  assign frame_err = frame_err_r;
`else
  assign frame_err = 1'b0;
`endif

  assign rx_bytes    = rx_bytes_r;
  assign rx_valid    = rx_valid_r;
  assign busy        = busy_r;
  assign spi.miso    = miso_r;
  assign spi.miso_oe = ~cs_level_s;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Self-checking bench for spi_slave_responder: bit-banged mode-0 master at clk/16
// with a received-word scoreboard checked whenever rx_valid pulses.
module tb_spi_slave_responder;

  localparam int N = 40;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic         clk;
  logic         reset;
  logic [N-1:0] tx_bytes;
  logic [N-1:0] rx_bytes;
  logic         rx_valid;
  logic         busy;
  logic         frame_err;

  spi_slave_responder_if bus ();

  spi_slave_responder #(.SIZE(N)) dut (
    .clk(clk), .reset(reset), .tx_bytes(tx_bytes), .rx_bytes(rx_bytes),
    .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err), .spi(bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_valid_cnt  = 0;
  int frame_err_cnt = 0;
  logic [N-1:0] rx_exp_q [$];
  logic [N-1:0] miso_exp_q [$];
  logic rx_valid_q  = 1'b0;
  logic frame_err_q = 1'b0;

  logic [N-1:0] mo_sh, mi_sh;
  logic first_miso, first_oe, last_miso;

  // Scoreboard monitor: every rx_valid pops an expected word; pulses must be one cycle wide.
  always @(negedge clk) begin
    logic [N-1:0] exp_w;
    if (rx_valid === 1'b1) begin
      rx_valid_cnt++;
      n_checks++;
      if (rx_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rx_unexpected: rx_valid with rx_bytes=%h, no frame expected", rx_bytes);
      end else begin
        exp_w = rx_exp_q.pop_front();
        if (rx_bytes !== exp_w) begin
          n_fail++;
          $display("FAIL rx_word: got %h expected %h", rx_bytes, exp_w);
        end
      end
      n_checks++;
      if (rx_valid_q !== 1'b0) begin
        n_fail++;
        $display("FAIL rx_valid_width: rx_valid high on consecutive cycles");
      end
    end
    if (frame_err === 1'b1) begin
      frame_err_cnt++;
      n_checks++;
      if (frame_err_q !== 1'b0) begin
        n_fail++;
        $display("FAIL frame_err_width: frame_err high on consecutive cycles");
      end
    end
    rx_valid_q  = rx_valid;
    frame_err_q = frame_err;
  end

  task automatic start_frame(input logic [N-1:0] mo);
    mo_sh = mo;
    mi_sh = '0;
    bus.mosi = mo_sh[N-1];
    bus.cs_n = 1'b0;
    repeat (4) @(negedge clk);
    first_miso = bus.miso;
    first_oe   = bus.miso_oe;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      mi_sh     = {mi_sh[N-2:0], bus.miso};
      last_miso = bus.miso;
      bus.sck   = 1'b1;
      repeat (8) @(negedge clk);
      bus.sck   = 1'b0;
      mo_sh     = {mo_sh[N-2:0], 1'b0};
      bus.mosi  = mo_sh[N-1];
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic end_frame();
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (rx_bytes !== 40'h0) begin n_fail++; $display("FAIL reset_rx_bytes: got %h expected 0", rx_bytes); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_checks++; if (bus.miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", bus.miso); end
    n_checks++; if (bus.miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_miso_oe: got %b expected 0", bus.miso_oe); end
    reset = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [N-1:0] w, t, e;
    int rv0;
    w = 40'h12_3456_789A;
    t = 40'hA5_5A_F0_0F_C3;
    tx_bytes = t;
    rx_exp_q.push_back(w);
    miso_exp_q.push_back(t);
    rv0 = rx_valid_cnt;
    start_frame(w);
    n_checks++; if (first_miso !== 1'b1) begin n_fail++; $display("FAIL first_bit_miso: got %b expected 1", first_miso); end
    n_checks++; if (first_oe !== 1'b1) begin n_fail++; $display("FAIL first_bit_oe: got %b expected 1", first_oe); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
    pulses(N);
    end_frame();
    repeat (3) @(negedge clk);
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_valid_early: got %b expected 0 at 3 clk", rx_valid); end
    @(negedge clk);
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rx_valid_timing: got %b expected 1 at 4 clk", rx_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    e = miso_exp_q.pop_front();
    n_checks++; if (mi_sh !== e) begin n_fail++; $display("FAIL basic_miso_word: got %h expected %h", mi_sh, e); end
    repeat (8) @(negedge clk);
    n_checks++; if (rx_valid_cnt - rv0 !== 1) begin n_fail++; $display("FAIL basic_rx_count: got %0d expected 1", rx_valid_cnt - rv0); end
  endtask

  task automatic test_short_frame();
    int rv0, fe0;
    rv0 = rx_valid_cnt;
    fe0 = frame_err_cnt;
    start_frame(40'hFF_0000_FFFF);
    pulses(N - 1);
    end_frame();
    repeat (10) @(negedge clk);
    n_checks++; if (rx_bytes !== 40'h12_3456_789A) begin n_fail++; $display("FAIL short_rx_bytes: got %h expected 123456789a", rx_bytes); end
    n_checks++; if (rx_valid_cnt - rv0 !== 0) begin n_fail++; $display("FAIL short_rx_count: got %0d expected 0", rx_valid_cnt - rv0); end
    n_checks++; if (frame_err_cnt - fe0 !== ERR_EXP) begin n_fail++; $display("FAIL short_frame_err: got %0d expected %0d", frame_err_cnt - fe0, ERR_EXP); end
  endtask

  task automatic test_long_frame();
    int rv0, fe0;
    rv0 = rx_valid_cnt;
    fe0 = frame_err_cnt;
    tx_bytes = 40'hFF_FFFF_FFFF;
    start_frame(40'h0F_0F0F_0F0F);
    pulses(N + 1);
    end_frame();
    repeat (10) @(negedge clk);
    n_checks++; if (last_miso !== 1'b0) begin n_fail++; $display("FAIL long_miso_bit41: got %b expected 0", last_miso); end
    n_checks++; if (mi_sh !== 40'hFF_FFFF_FFFE) begin n_fail++; $display("FAIL long_miso_word: got %h expected fffffffffe", mi_sh); end
    n_checks++; if (rx_valid_cnt - rv0 !== 0) begin n_fail++; $display("FAIL long_rx_count: got %0d expected 0", rx_valid_cnt - rv0); end
    n_checks++; if (frame_err_cnt - fe0 !== ERR_EXP) begin n_fail++; $display("FAIL long_frame_err: got %0d expected %0d", frame_err_cnt - fe0, ERR_EXP); end
  endtask

  task automatic test_reset_mid_frame();
    int rv0, fe0;
    logic [N-1:0] w;
    rv0 = rx_valid_cnt;
    fe0 = frame_err_cnt;
    tx_bytes = 40'hC0_FFEE_0011;
    start_frame(40'hDE_ADBE_EF01);
    pulses(20);
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++; if (rx_bytes !== 40'h0) begin n_fail++; $display("FAIL midrst_rx_bytes: got %h expected 0", rx_bytes); end
    n_checks++; if (bus.miso !== 1'b0) begin n_fail++; $display("FAIL midrst_miso: got %b expected 0", bus.miso); end
    n_checks++; if (bus.miso_oe !== 1'b0) begin n_fail++; $display("FAIL midrst_miso_oe: got %b expected 0", bus.miso_oe); end
    @(negedge clk);
    reset = 1'b0;
    pulses(20);
    end_frame();
    repeat (10) @(negedge clk);
    n_checks++; if (rx_valid_cnt - rv0 !== 0) begin n_fail++; $display("FAIL midrst_rx_count: got %0d expected 0", rx_valid_cnt - rv0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_after: got %b expected 0", busy); end
    n_checks++; if (frame_err_cnt - fe0 !== 0) begin n_fail++; $display("FAIL midrst_frame_err: got %0d expected 0", frame_err_cnt - fe0); end
    w = 40'h55_AA33_CC0F;
    rx_exp_q.push_back(w);
    start_frame(w);
    pulses(N);
    end_frame();
    repeat (10) @(negedge clk);
    n_checks++; if (rx_valid_cnt - rv0 !== 1) begin n_fail++; $display("FAIL midrst_next_count: got %0d expected 1", rx_valid_cnt - rv0); end
    n_checks++; if (mi_sh !== 40'hC0_FFEE_0011) begin n_fail++; $display("FAIL midrst_next_miso: got %h expected c0ffee0011", mi_sh); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] w1, w2, t1, t2, e;
    int rv0;
    w1 = 40'h01_2345_6789;
    w2 = 40'hFE_DCBA_9876;
    t1 = 40'h3C_3C3C_3C3C;
    t2 = 40'h81_7E18_E7A5;
    rv0 = rx_valid_cnt;
    tx_bytes = t1;
    rx_exp_q.push_back(w1);
    miso_exp_q.push_back(t1);
    start_frame(w1);
    pulses(10);
    tx_bytes = t2;
    pulses(N - 10);
    end_frame();
    e = miso_exp_q.pop_front();
    n_checks++; if (mi_sh !== e) begin n_fail++; $display("FAIL b2b_miso_frame1: got %h expected %h", mi_sh, e); end
    repeat (8) @(negedge clk);
    rx_exp_q.push_back(w2);
    miso_exp_q.push_back(t2);
    start_frame(w2);
    pulses(N);
    end_frame();
    e = miso_exp_q.pop_front();
    n_checks++; if (mi_sh !== e) begin n_fail++; $display("FAIL b2b_miso_frame2: got %h expected %h", mi_sh, e); end
    repeat (10) @(negedge clk);
    n_checks++; if (rx_valid_cnt - rv0 !== 2) begin n_fail++; $display("FAIL b2b_rx_count: got %0d expected 2", rx_valid_cnt - rv0); end
    n_checks++; if (rx_bytes !== w2) begin n_fail++; $display("FAIL b2b_rx_bytes: got %h expected %h", rx_bytes, w2); end
  endtask

  initial begin
    reset    = 1'b1;
    tx_bytes = '0;
    bus.cs_n = 1'b1;
    bus.sck  = 1'b0;
    bus.mosi = 1'b0;
    test_reset();
    test_basic();
    test_short_frame();
    test_long_frame();
    test_reset_mid_frame();
    test_back_to_back();
    n_checks++;
    if (rx_exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d words never received, expected 0", rx_exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
